uart_apb_host: RTL
==================

UART_APB_HOST -- requirements
Module: uart_apb_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning max cycles in WAIT_RSP before a timeout response (legal 2..2^32-1).
REQ-002 SHALL use a single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all logic.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  user command request.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  2  target register address.
REQ-009 req_wdata  in  5  write data, ignored for reads.
REQ-010 rsp_valid  out  1  one-cycle response strobe.
REQ-011 rsp_rdata  out  5  read data, 0 for writes and errors.
REQ-012 rsp_status  out  2  00 OK, 01 BAD_ACK, 10 MISMATCH, 11 TIMEOUT.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 tx_data  out  8  command byte to the uart_tx byte port.
REQ-015 tx_data_valid  out  1  command byte offered.
REQ-016 tx_ready  in  1  uart_tx can accept a byte.
REQ-017 rx_data  in  8  byte from the uart_rx byte port.
REQ-018 rx_data_valid  in  1  one-cycle strobe, rx_data valid.

Function
REQ-019 SHALL implement the FSM IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE, with all outputs registered.
REQ-020 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 Request acceptance SHALL occur on the cycle with req_valid && req_ready; the block latches write, addr and wdata and moves to SEND.
REQ-022 The command byte SHALL be {wdata[4:0], addr[1:0], write}; for reads wdata is forced to 0.
REQ-023 In SEND, tx_data_valid SHALL be 1 and tx_data SHALL be held stable.
REQ-024 The byte is accepted on the cycle with tx_data_valid && tx_ready; on the next cycle tx_data_valid SHALL be 0 and the state SHALL be WAIT_RSP.
REQ-025 On entering WAIT_RSP, a 32-bit timeout counter SHALL clear to 0 and then increment once per cycle while in WAIT_RSP.
REQ-026 Write response check in WAIT_RSP: rx byte == 8'h06 gives status 00; any other byte gives status 01.
REQ-027 Read response check in WAIT_RSP: if rx[0] == 1 and rx[2:1] == latched addr, status is 00 and rsp_rdata = rx[7:3].
- Otherwise status is 10 and rsp_rdata = 0.
REQ-028 If the counter reaches TIMEOUT_CYCLES-1 with no rx_data_valid, the block SHALL go to DONE with status 11.
REQ-029 If rx_data_valid arrives in the same cycle as the timeout, the rx byte SHALL take priority over the timeout.
REQ-030 In DONE, rsp_valid SHALL be 1 for exactly one cycle with rsp_status and rsp_rdata valid; the next state is IDLE.
REQ-031 rsp_rdata and rsp_status SHALL hold their values until the next DONE.
REQ-032 rx bytes arriving in IDLE, SEND or DONE SHALL be discarded with no effect on any output.
REQ-033 Only the first rx byte in WAIT_RSP SHALL be evaluated.
REQ-034 A request issued while not in IDLE SHALL NOT be accepted; the user holds req_valid until req_ready is seen.
REQ-035 Back-to-back: the earliest next acceptance SHALL be the cycle after rsp_valid.
- Minimum request-to-request period is 4 cycles plus tx wait plus response wait.

Reset
REQ-036 While rst=1, the block SHALL be in IDLE and the outputs SHALL be: tx_data_valid=0, tx_data=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, busy=0, req_ready=0.
REQ-037 req_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-038 rst asserted in any state, including mid-SEND or mid-WAIT_RSP, SHALL abort the transaction with no rsp_valid.
REQ-039 A late rx byte arriving after reset SHALL be discarded per REQ-032.

Verification
REQ-040 Write, addr=2, wdata=0x15 -> tx_data=0xAD; then rx 0x06 -> one-cycle rsp_valid with status 00, rdata 0x00.
REQ-041 Read, addr=1 -> tx_data=0x02; then rx 0x5B -> rsp_valid with status 00, rdata 0x0B.
REQ-042 Write, addr=0, wdata=0x01 -> tx_data=0x09; then rx 0x15 -> status 01.
- Separately: read, addr=1, then rx 0x5D -> status 10, rdata 0x00.
REQ-043 TIMEOUT_CYCLES=16, read with no rx byte -> rsp_valid 16 cycles after WAIT_RSP entry, status 11.
- Repeat with rx_data_valid on the 16th cycle -> the rx byte is evaluated instead of a timeout.
REQ-044 Hold tx_ready=0 for 10 cycles -> tx_data_valid stays 1 and tx_data stays stable.
- Raise tx_ready for 1 cycle -> byte accepted and the block moves to WAIT_RSP.
REQ-045 Inject an rx byte in IDLE -> no rsp_valid.
- Assert rst mid-WAIT_RSP, then send rx 0x06 -> no rsp_valid, and req_ready=1 from the first cycle after rst deasserts.

Source files
------------

// File: rtl/uart_apb_host.sv
// Byte-level command host: sends one command byte to a UART transmitter and
// waits for a single response byte (or a timeout) before reporting a status.
module uart_apb_host #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [4:0] req_wdata,
    output logic       rsp_valid,
    output logic [4:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP,
        DONE
    } state_t;

    localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_ACK  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    state_t      state, state_nxt;
    logic        wr_q, wr_nxt;
    logic [1:0]  addr_q, addr_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [7:0]  tx_data_nxt;
    logic [4:0]  rdata_nxt;
    logic [1:0]  status_nxt;

    always_comb begin
        state_nxt   = state;
        wr_nxt      = wr_q;
        addr_nxt    = addr_q;
        cnt_nxt     = cnt + 32'd1;
        tx_data_nxt = tx_data;
        rdata_nxt   = rsp_rdata;
        status_nxt  = rsp_status;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req_valid && req_ready) begin
                    state_nxt   = SEND;
                    wr_nxt      = req_write;
                    addr_nxt    = req_addr;
                    tx_data_nxt = {(req_write ? req_wdata : 5'd0), req_addr, req_write};
                end
            end
            SEND: begin
                // Counter is zeroed here so it reads 0 on the first WAIT_RSP cycle.
                cnt_nxt = '0;
                if (tx_data_valid && tx_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rx_data_valid) begin
                    state_nxt = DONE;
                    rdata_nxt = '0;
                    if (wr_q) begin
                        status_nxt = (rx_data == 8'h06) ? ST_OK : ST_BAD_ACK;
                    end else if (rx_data[0] && (rx_data[2:1] == addr_q)) begin
                        status_nxt = ST_OK;
                        rdata_nxt  = rx_data[7:3];
                    end else begin
                        status_nxt = ST_MISMATCH;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = DONE;
                    status_nxt = ST_TIMEOUT;
                    rdata_nxt  = '0;
                end
            end
            DONE: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state so they line up
    // with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            cnt           <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_status    <= '0;
            busy          <= 1'b0;
            req_ready     <= 1'b0;
        end else begin
            state         <= state_nxt;
            wr_q          <= wr_nxt;
            addr_q        <= addr_nxt;
            cnt           <= cnt_nxt;
            tx_data       <= tx_data_nxt;
            tx_data_valid <= (state_nxt == SEND);
            rsp_valid     <= (state_nxt == DONE);
            rsp_rdata     <= rdata_nxt;
            rsp_status    <= status_nxt;
            busy          <= (state_nxt != IDLE);
            req_ready     <= (state_nxt == IDLE);
        end
    end

endmodule
